run_monitor: RTL and testbench

Synthesizable run controller and result checker for the processor `top` in simulation and FPGA bring-up. It sits beside `top` on the data-memory bus (`MemWrite`, `DataAdr`, `WriteData`).
- Sequences the core's reset.
- Bounds the run with a cycle watchdog.
- Decides pass/fail from the core's memory writes.
- Generalises the fixed reset pulse and fixed run time of the bench to parametrised reset length, timeout, pass signature and address window, and adds write statistics.

---
 rtl/run_monitor.sv | 168 ++++++++++++++++
 tb/tb_run_monitor.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/run_monitor.sv
`default_nettype none
// ============================================================================
// Module   : run_monitor
// Brief    : Run controller and result checker for a processor core.
//            Sequences the core reset, bounds the run with a cycle watchdog,
//            and decides pass/fail from stores seen on the data-memory bus.
// Revision : 1.0 - initial release
// ============================================================================
module run_monitor #(
    parameter int RESET_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int PASS_ADDR      = 100,
    parameter int PASS_DATA      = 25,
    parameter int ADDR_LIMIT     = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemWrite,
    input  logic [ADDR_WIDTH-1:0] DataAdr,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic                  core_reset,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic [15:0]           write_count,
    output logic [31:0]           cycle_count,
    output logic [ADDR_WIDTH-1:0] last_adr,
    output logic [DATA_WIDTH-1:0] last_data
);

    // State encoding
    localparam logic [2:0] c_ST_HOLD    = 3'd0;
    localparam logic [2:0] c_ST_RUN     = 3'd1;
    localparam logic [2:0] c_ST_PASS    = 3'd2;
    localparam logic [2:0] c_ST_FAIL    = 3'd3;
    localparam logic [2:0] c_ST_TIMEOUT = 3'd4;

    // Parameter values resized to the buses they are compared against
    localparam logic [31:0]           c_HOLD_LAST  = 32'(RESET_CYCLES - 1);
    localparam logic [31:0]           c_TIMEOUT    = 32'(TIMEOUT_CYCLES);
    localparam logic [ADDR_WIDTH-1:0] c_PASS_ADDR  = ADDR_WIDTH'(PASS_ADDR);
    localparam logic [DATA_WIDTH-1:0] c_PASS_DATA  = DATA_WIDTH'(PASS_DATA);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_LIMIT = ADDR_WIDTH'(ADDR_LIMIT);

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [31:0]           r_hold_cnt;
    logic [15:0]           r_write_count;
    logic [31:0]           r_cycle_count;
    logic [ADDR_WIDTH-1:0] r_last_adr;
    logic [DATA_WIDTH-1:0] r_last_data;

    logic w_in_run;
    logic w_store;
    logic w_sig_addr;
    logic w_wdog_hit;

    assign w_in_run   = (r_state == c_ST_RUN);
    assign w_store    = w_in_run && MemWrite;
    assign w_sig_addr = (DataAdr == c_PASS_ADDR);
    // True on the edge that would bring the run length up to the limit
    assign w_wdog_hit = ((r_cycle_count + 32'd1) == c_TIMEOUT);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_HOLD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: a pass/fail decision on a store outranks the watchdog
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_HOLD: begin
                if (r_hold_cnt == c_HOLD_LAST) begin
                    w_next_state = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (MemWrite && w_sig_addr && (WriteData == c_PASS_DATA)) begin
                    w_next_state = c_ST_PASS;
                end else if (MemWrite && w_sig_addr) begin
                    w_next_state = c_ST_FAIL;
                end else if (MemWrite && (DataAdr >= c_ADDR_LIMIT)) begin
                    w_next_state = c_ST_FAIL;
                end else if (w_wdog_hit) begin
                    w_next_state = c_ST_TIMEOUT;
                end
            end
            c_ST_PASS, c_ST_FAIL, c_ST_TIMEOUT: begin
                w_next_state = r_state;
            end
            default: begin
                w_next_state = c_ST_HOLD;
            end
        endcase
    end

    // Output decode from the registered state only, so no input reaches an output
    always_comb begin
        core_reset = 1'b1;
        done       = 1'b0;
        pass       = 1'b0;
        fail       = 1'b0;
        timeout    = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                core_reset = 1'b0;
            end
            c_ST_PASS: begin
                done = 1'b1;
                pass = 1'b1;
            end
            c_ST_FAIL: begin
                done = 1'b1;
                fail = 1'b1;
            end
            c_ST_TIMEOUT: begin
                done    = 1'b1;
                timeout = 1'b1;
            end
            default: begin
                core_reset = 1'b1;
            end
        endcase
    end

    // Hold counter: counts edges spent in HOLD after reset releases
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_cnt <= 32'd0;
        end else if ((r_state == c_ST_HOLD) && (r_hold_cnt != c_HOLD_LAST)) begin
            r_hold_cnt <= r_hold_cnt + 32'd1;
        end
    end

    // Run statistics: only advance while running, frozen in terminal states
    always_ff @(posedge clk) begin
        if (reset) begin
            r_write_count <= 16'd0;
            r_cycle_count <= 32'd0;
            r_last_adr    <= '0;
            r_last_data   <= '0;
        end else if (w_in_run) begin
            r_cycle_count <= r_cycle_count + 32'd1;
            if (w_store) begin
                if (r_write_count != 16'hFFFF) begin
                    r_write_count <= r_write_count + 16'd1;
                end
                r_last_adr  <= DataAdr;
                r_last_data <= WriteData;
            end
        end
    end

    assign write_count = r_write_count;
    assign cycle_count = r_cycle_count;
    assign last_adr    = r_last_adr;
    assign last_data   = r_last_data;

endmodule
`default_nettype wire

// File: tb/tb_run_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_run_monitor
// Brief    : Directed self-checking bench for run_monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_run_monitor;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        core_reset;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [15:0] write_count;
    logic [31:0] cycle_count;
    logic [31:0] last_adr;
    logic [31:0] last_data;

    int n_cmp;
    int n_err;

    run_monitor #(
        .RESET_CYCLES   (4),
        .TIMEOUT_CYCLES (10),
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (32),
        .PASS_ADDR      (100),
        .PASS_DATA      (25),
        .ADDR_LIMIT     (256)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .MemWrite    (MemWrite),
        .DataAdr     (DataAdr),
        .WriteData   (WriteData),
        .core_reset  (core_reset),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .write_count (write_count),
        .cycle_count (cycle_count),
        .last_adr    (last_adr),
        .last_data   (last_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Store presented for exactly one edge
    task automatic store(input logic [31:0] adr, input logic [31:0] data);
        MemWrite  = 1'b1;
        DataAdr   = adr;
        WriteData = data;
        tick();
        MemWrite  = 1'b0;
        DataAdr   = 32'd0;
        WriteData = 32'd0;
    endtask

    // One-cycle reset pulse, then the four HOLD edges into RUN
    task automatic restart();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (4) tick();
    endtask

    task automatic chk_flags(input string tag, input logic d, input logic p,
                             input logic f, input logic t);
        chk({tag, ".done"},    64'(done),    64'(d));
        chk({tag, ".pass"},    64'(pass),    64'(p));
        chk({tag, ".fail"},    64'(fail),    64'(f));
        chk({tag, ".timeout"}, 64'(timeout), 64'(t));
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        MemWrite  = 1'b0;
        DataAdr   = 32'd0;
        WriteData = 32'd0;

        // Reset timing: reset high for 3 edges
        repeat (3) tick();
        chk("rst.core_reset", 64'(core_reset), 64'd1);
        chk_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.write_count", 64'(write_count), 64'd0);
        chk("rst.cycle_count", 64'(cycle_count), 64'd0);
        chk("rst.last_adr",    64'(last_adr),    64'd0);
        reset = 1'b0;
        tick();
        chk("hold1.core_reset", 64'(core_reset), 64'd1);
        tick();
        chk("hold2.core_reset", 64'(core_reset), 64'd1);
        tick();
        chk("hold3.core_reset", 64'(core_reset), 64'd1);
        tick();
        chk("hold4.core_reset", 64'(core_reset), 64'd0);
        chk_flags("run0", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("run0.cycle_count", 64'(cycle_count), 64'd0);

        // Pass run
        store(32'd20, 32'd7);
        chk("pass.s1.write_count", 64'(write_count), 64'd1);
        chk("pass.s1.cycle_count", 64'(cycle_count), 64'd1);
        chk("pass.s1.last_data",   64'(last_data),   64'd7);
        store(32'd24, 32'd9);
        chk("pass.s2.last_adr", 64'(last_adr), 64'd24);
        chk_flags("pass.s2", 1'b0, 1'b0, 1'b0, 1'b0);
        store(32'd100, 32'd25);
        chk_flags("pass.s3", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("pass.s3.write_count", 64'(write_count), 64'd3);
        chk("pass.s3.last_adr",    64'(last_adr),    64'd100);
        chk("pass.s3.last_data",   64'(last_data),   64'd25);
        chk("pass.s3.core_reset",  64'(core_reset),  64'd1);
        chk("pass.s3.cycle_count", 64'(cycle_count), 64'd3);
        store(32'd50, 32'd1);
        store(32'd100, 32'd24);
        tick();
        chk_flags("pass.sticky", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("pass.sticky.write_count", 64'(write_count), 64'd3);
        chk("pass.sticky.last_adr",    64'(last_adr),    64'd100);
        chk("pass.sticky.cycle_count", 64'(cycle_count), 64'd3);

        // Reset from a terminal state clears everything
        reset = 1'b1;
        tick();
        chk_flags("treset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("treset.core_reset",  64'(core_reset),  64'd1);
        chk("treset.write_count", 64'(write_count), 64'd0);
        chk("treset.last_data",   64'(last_data),   64'd0);
        reset = 1'b0;
        repeat (4) tick();

        // Wrong signature value
        store(32'd100, 32'd24);
        chk_flags("wrongsig", 1'b1, 1'b0, 1'b1, 1'b0);
        chk("wrongsig.write_count", 64'(write_count), 64'd1);

        // Address limit boundary: 255 legal, 256 illegal
        restart();
        store(32'd255, 32'd1);
        chk_flags("adr255", 1'b0, 1'b0, 1'b0, 1'b0);
        store(32'd256, 32'd5);
        chk_flags("adr256", 1'b1, 1'b0, 1'b1, 1'b0);
        chk("adr256.write_count", 64'(write_count), 64'd2);

        // Illegal address well above the limit
        restart();
        store(32'd300, 32'd5);
        chk_flags("adr300", 1'b1, 1'b0, 1'b1, 1'b0);
        chk("adr300.last_adr", 64'(last_adr), 64'd300);

        // Watchdog: no stores, expires on RUN edge 10
        restart();
        repeat (9) tick();
        chk("wd9.cycle_count", 64'(cycle_count), 64'd9);
        chk_flags("wd9", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_flags("wd10", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("wd10.cycle_count", 64'(cycle_count), 64'd10);
        chk("wd10.core_reset",  64'(core_reset),  64'd1);
        repeat (2) tick();
        chk("wd.frozen.cycle_count", 64'(cycle_count), 64'd10);

        // Signature on the watchdog edge wins
        restart();
        repeat (9) tick();
        store(32'd100, 32'd25);
        chk_flags("prio", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("prio.cycle_count", 64'(cycle_count), 64'd10);

        // Reset mid-run after 5 stores
        restart();
        for (int i = 0; i < 5; i++) store(32'(4 * i), 32'(i + 1));
        chk("mid.write_count", 64'(write_count), 64'd5);
        chk("mid.last_data",   64'(last_data),   64'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst.write_count", 64'(write_count), 64'd0);
        chk("midrst.cycle_count", 64'(cycle_count), 64'd0);
        chk("midrst.last_adr",    64'(last_adr),    64'd0);
        chk("midrst.core_reset",  64'(core_reset),  64'd1);
        // Stores during HOLD must be ignored
        MemWrite  = 1'b1;
        DataAdr   = 32'd100;
        WriteData = 32'd25;
        repeat (3) tick();
        chk("midhold3.core_reset", 64'(core_reset), 64'd1);
        MemWrite  = 1'b0;
        tick();
        chk("midhold4.core_reset",  64'(core_reset),  64'd0);
        chk("midhold4.write_count", 64'(write_count), 64'd0);
        chk_flags("midhold4", 1'b0, 1'b0, 1'b0, 1'b0);
        store(32'd100, 32'd25);
        chk_flags("rerun", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rerun.write_count", 64'(write_count), 64'd1);
        chk("rerun.cycle_count", 64'(cycle_count), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
